// File: rtl/score_keeper.sv
// score_keeper: current-game BCD score and per-user high-score table.
// Optional feature macro: SCORE_KEEPER_HISCORE_EN compiles in the high-score
// table, the COMMIT compare/write, new_high and the display_sel=1 view.
// Without it, new_high is tied low and the current score is always shown.
`timescale 1ns/1ps
module score_keeper #(
  parameter int unsigned NUM_USERS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [2:0] user_ID,
  input  logic       game_start_pulse,
  input  logic       catch_pulse,
  input  logic [3:0] catch_points,
  input  logic       game_over_pulse,
  input  logic       display_sel,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       new_high,
  output logic       playing
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 2 * DIGIT_W;
  localparam int unsigned USER_W  = 3;

  typedef enum logic [2:0] {
    LOCKED = 3'd0,
    IDLE   = 3'd1,
    PLAY   = 3'd2,
    COMMIT = 3'd3,
    SHOW   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [USER_W-1:0]   active_user_q, active_user_d;
  logic [DIGIT_W-1:0]  tens_q, tens_d;
  logic [DIGIT_W-1:0]  ones_q, ones_d;

  logic [DIGIT_W-1:0]  pts_c;
  logic [DIGIT_W:0]    ones_sum_c;
  logic                carry_c;
  logic [DIGIT_W-1:0]  add_tens_c;
  logic [DIGIT_W-1:0]  add_ones_c;

  // Clamp the catch value and form the saturating BCD sum of score + points
  always_comb begin
    pts_c      = (catch_points > 4'd9) ? 4'd9 : catch_points;
    ones_sum_c = {1'b0, ones_q} + {1'b0, pts_c};
    carry_c    = (ones_sum_c > 5'd9);
    add_ones_c = carry_c ? DIGIT_W'(ones_sum_c - 5'd10) : ones_sum_c[DIGIT_W-1:0];
    add_tens_c = tens_q + DIGIT_W'(carry_c);
    if (carry_c && (tens_q == 4'd9)) begin
      add_tens_c = 4'd9;
      add_ones_c = 4'd9;
    end
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  logic [SCORE_W-1:0]  hs_q [NUM_USERS];
  logic [SCORE_W-1:0]  hs_d [NUM_USERS];
  logic                new_high_q, new_high_d;
  logic [SCORE_W-1:0]  hs_rd_c;
  logic                in_range_c;

  // Look up the active user's table entry; out-of-range IDs read as 00
  always_comb begin
    hs_rd_c    = '0;
    in_range_c = 1'b0;
    for (int i = 0; i < int'(NUM_USERS); i++) begin
      if (active_user_q == USER_W'(i)) begin
        hs_rd_c    = hs_q[i];
        in_range_c = 1'b1;
      end
    end
  end
`endif

  // Next-state, score, user latch and (optionally) table update
  always_comb begin
    state_d       = state_q;
    active_user_d = active_user_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
`ifdef SCORE_KEEPER_HISCORE_EN
    hs_d          = hs_q;
    new_high_d    = new_high_q;
`endif
    if (!valid_in) begin
      state_d = LOCKED;
      tens_d  = '0;
      ones_d  = '0;
`ifdef SCORE_KEEPER_HISCORE_EN
      new_high_d = 1'b0;
`endif
    end else begin
      case (state_q)
        LOCKED: begin
          active_user_d = user_ID;
          state_d       = IDLE;
        end
        IDLE, SHOW: begin
          if (game_start_pulse) begin
            tens_d  = '0;
            ones_d  = '0;
            state_d = PLAY;
`ifdef SCORE_KEEPER_HISCORE_EN
            new_high_d = 1'b0;
`endif
          end
        end
        PLAY: begin
          if (game_start_pulse) begin
            tens_d = '0;
            ones_d = '0;
          end else begin
            if (catch_pulse) begin
              tens_d = add_tens_c;
              ones_d = add_ones_c;
            end
            if (game_over_pulse) begin
              state_d = COMMIT;
            end
          end
        end
        COMMIT: begin
          state_d = SHOW;
`ifdef SCORE_KEEPER_HISCORE_EN
          if (in_range_c && ({tens_q, ones_q} > hs_rd_c)) begin
            for (int i = 0; i < int'(NUM_USERS); i++) begin
              if (active_user_q == USER_W'(i)) begin
                hs_d[i] = {tens_q, ones_q};
              end
            end
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
`endif
        end
        default: begin
          state_d = LOCKED;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOCKED;
      active_user_q <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
`ifdef SCORE_KEEPER_HISCORE_EN
      new_high_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_USERS); i++) begin
        hs_q[i] <= '0;
      end
`endif
    end else begin
      state_q       <= state_d;
      active_user_q <= active_user_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
`ifdef SCORE_KEEPER_HISCORE_EN
      new_high_q    <= new_high_d;
      hs_q          <= hs_d;
`endif
    end
  end

  assign playing = (state_q == PLAY);

`ifdef SCORE_KEEPER_HISCORE_EN
  assign new_high = new_high_q;

  // Display mux: current score or active user's high score, same cycle
  always_comb begin
    score_tens = tens_q;
    score_ones = ones_q;
    if (display_sel) begin
      score_tens = hs_rd_c[SCORE_W-1:DIGIT_W];
      score_ones = hs_rd_c[DIGIT_W-1:0];
    end
  end
`else
  logic unused_cfg;

  assign new_high   = 1'b0;
  assign score_tens = tens_q;
  assign score_ones = ones_q;
  assign unused_cfg = ^{display_sel, 32'(NUM_USERS)};
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed, table-driven bench for score_keeper (either build of the macro).
`timescale 1ns/1ps
module tb_score_keeper;

`ifdef SCORE_KEEPER_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [2:0] user_ID;
  logic       game_start_pulse;
  logic       catch_pulse;
  logic [3:0] catch_points;
  logic       game_over_pulse;
  logic       display_sel;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       new_high;
  logic       playing;

  int n_cmp  = 0;
  int n_fail = 0;

  score_keeper #(.NUM_USERS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .user_ID          (user_ID),
    .game_start_pulse (game_start_pulse),
    .catch_pulse      (catch_pulse),
    .catch_points     (catch_points),
    .game_over_pulse  (game_over_pulse),
    .display_sel      (display_sel),
    .score_tens       (score_tens),
    .score_ones       (score_ones),
    .new_high         (new_high),
    .playing          (playing)
  );

  always #5 clk = ~clk;

  // One record = inputs for one clock edge and the state seen after it.
  // ct/co: current score, ht/ho: active user's high score, nh: new_high when enabled.
  typedef struct {
    logic       v;
    logic [2:0] id;
    logic       st;
    logic       ca;
    logic [3:0] pts;
    logic       ov;
    logic       sel;
    int         ct;
    int         co;
    int         ht;
    int         ho;
    logic       nh;
    logic       pl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [2:0] id, logic st, logic ca, logic [3:0] pts,
                              logic ov, logic sel, int ct, int co, int ht, int ho,
                              logic nh, logic pl);
    vec_t r;
    r.v = v; r.id = id; r.st = st; r.ca = ca; r.pts = pts; r.ov = ov; r.sel = sel;
    r.ct = ct; r.co = co; r.ht = ht; r.ho = ho; r.nh = nh; r.pl = pl;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] id, input logic st, input logic ca,
                       input logic [3:0] pts, input logic ov, input logic sel);
    valid_in         = v;
    user_ID          = id;
    game_start_pulse = st;
    catch_pulse      = ca;
    catch_points     = pts;
    game_over_pulse  = ov;
    display_sel      = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int t, input int o, input logic nh, input logic pl);
    chk({tag, " tens"}, int'(score_tens), t);
    chk({tag, " ones"}, int'(score_ones), o);
    chk({tag, " new_high"}, int'(new_high), int'(nh));
    chk({tag, " playing"}, int'(playing), int'(pl));
  endtask

  initial begin
    int exp_t;
    int exp_o;
    int exp_s;

    // Login, two catches, first commit
    vecs.push_back(mk(0,0,0,1,5,0,0, 0,0, 0,0, 0,0));  // LOCKED ignores catch
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0, 0,0));  // -> IDLE as user 0
    vecs.push_back(mk(1,0,0,1,3,0,0, 0,0, 0,0, 0,0));  // IDLE ignores catch
    vecs.push_back(mk(1,0,1,0,0,0,0, 0,0, 0,0, 0,1));  // start -> PLAY
    vecs.push_back(mk(1,0,0,1,7,0,0, 0,7, 0,0, 0,1));
    vecs.push_back(mk(1,0,0,1,5,0,0, 1,2, 0,0, 0,1));  // back-to-back catch, carry
    vecs.push_back(mk(1,0,0,0,0,1,1, 1,2, 0,0, 0,0));  // over -> COMMIT
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,2, 1,2, 1,0));  // -> SHOW, high 12
    vecs.push_back(mk(1,0,0,1,5,0,0, 1,2, 1,2, 1,0));  // SHOW ignores catch
    // Second game 08: not a new high
    vecs.push_back(mk(1,0,1,0,0,0,0, 0,0, 1,2, 0,1));
    vecs.push_back(mk(1,0,0,1,8,0,0, 0,8, 1,2, 0,1));
    vecs.push_back(mk(1,0,0,0,0,1,0, 0,8, 1,2, 0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,8, 1,2, 0,0));
    // Third game: clamp, then catch together with game over from 10
    vecs.push_back(mk(1,0,1,0,0,0,0, 0,0, 1,2, 0,1));
    vecs.push_back(mk(1,0,0,1,15,0,0, 0,9, 1,2, 0,1)); // 15 clamps to 9
    vecs.push_back(mk(1,0,0,1,1,0,0, 1,0, 1,2, 0,1));
    vecs.push_back(mk(1,0,0,1,4,1,1, 1,4, 1,2, 0,0));  // catch + over
    vecs.push_back(mk(1,0,0,0,0,0,1, 1,4, 1,4, 1,0));  // committed 14
    // Start has priority over game over
    vecs.push_back(mk(1,0,1,0,0,1,0, 0,0, 1,4, 0,1));
    vecs.push_back(mk(1,0,0,1,3,0,0, 0,3, 1,4, 0,1));
    vecs.push_back(mk(1,0,1,0,0,1,0, 0,0, 1,4, 0,1));  // restart in PLAY
    vecs.push_back(mk(1,0,0,1,9,0,0, 0,9, 1,4, 0,1));
    // Logout mid-game, user 1, then back to user 0
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 1,4, 0,0));
    vecs.push_back(mk(1,1,0,0,0,0,1, 0,0, 0,0, 0,0));
    vecs.push_back(mk(1,5,0,0,0,0,1, 0,0, 0,0, 0,0));  // ID change ignored while logged in
    vecs.push_back(mk(1,5,1,0,0,0,0, 0,0, 0,0, 0,1));
    vecs.push_back(mk(1,5,0,1,6,0,0, 0,6, 0,0, 0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,0, 1,4, 0,0));  // user 0 table retained
    // Out-of-range user 7
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 1,4, 0,0));
    vecs.push_back(mk(1,7,0,0,0,0,1, 0,0, 0,0, 0,0));
    vecs.push_back(mk(1,7,1,0,0,0,0, 0,0, 0,0, 0,1));
    vecs.push_back(mk(1,7,0,1,9,0,0, 0,9, 0,0, 0,1));
    vecs.push_back(mk(1,7,0,1,9,0,0, 1,8, 0,0, 0,1));
    vecs.push_back(mk(1,7,0,1,2,0,0, 2,0, 0,0, 0,1));
    vecs.push_back(mk(1,7,0,0,0,1,0, 2,0, 0,0, 0,0));
    vecs.push_back(mk(1,7,0,0,0,0,1, 2,0, 0,0, 0,0));  // SHOW, no new high
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,0, 1,4, 0,0));  // user 7 wrote nothing

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #23;
    chk_all("reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].id, vecs[i].st, vecs[i].ca, vecs[i].pts, vecs[i].ov, vecs[i].sel);
      step();
      exp_t = (vecs[i].sel && HS_EN) ? vecs[i].ht : vecs[i].ct;
      exp_o = (vecs[i].sel && HS_EN) ? vecs[i].ho : vecs[i].co;
      chk_all($sformatf("row%0d", i), exp_t, exp_o, vecs[i].nh && HS_EN, vecs[i].pl);
    end

    // display_sel change is visible without a clock edge (user 0, high 14)
    display_sel = 1'b0;
    #1;
    chk("sel_comb tens", int'(score_tens), 0);
    display_sel = 1'b1;
    #1;
    chk("sel_comb tens_hs", int'(score_tens), HS_EN ? 1 : 0);
    chk("sel_comb ones_hs", int'(score_ones), HS_EN ? 4 : 0);

    // Saturation: twelve catches of 9 stop at 99
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    chk_all("sat start", 0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      drive(1, 0, 0, 1, 9, 0, 0);
      step();
      exp_s = (9 * k > 99) ? 99 : 9 * k;
      chk_all($sformatf("sat%0d", k), exp_s / 10, exp_s % 10, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-game clears everything, including the table
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 1);
    step();
    chk_all("post_rst table", 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
